icache_controller: RTL and testbench
====================================

# icache_controller

Direct-mapped instruction cache with a refill state machine. Serves the fetch stage's word-address lookup port combinationally, deasserts `fetch_ready_o` on a miss, refills the missing line from a single-word memory port with a req/ack handshake, and supports a full invalidate (`fence.i`). Sits between the fetch stage and the memory arbiter.

## Interface
Parameters:
- `LINE_WORDS`, 4, words per line (power of two, ≥2); `OFF_W = log2(LINE_WORDS)`
- `LINES`, 64, number of lines (power of two); `IDX_W = log2(LINES)`; `TAG_W = 30 - IDX_W - OFF_W`

Ports:
- `clk_i` in 1: clock
- `rst_i` in 1: reset, synchronous, active-high
- `fetch_address_i` in [31:2]: word address from fetch stage, split {tag, idx, off}
- `fetch_data_o` out [31:2]: instruction bits [31:2] of addressed word
- `fetch_ready_o` out 1: hit; `fetch_data_o` valid this cycle
- `flush_i` in 1: invalidate all lines
- `mem_req_o` out 1: refill word request
- `mem_addr_o` out [31:2]: refill word address
- `mem_ack_i` in 1: `mem_data_i` valid, request consumed
- `mem_data_i` in [31:0]: returned word; bits [1:0] ignored

## Operation
- Storage:
  - `valid[LINES]` in flops.
  - `tag[LINES][TAG_W]`.
  - `data[LINES*LINE_WORDS][30]`, read combinationally.
- States:
  - IDLE (lookup).
  - REFILL (fetching a line).
- IDLE:
  - `fetch_ready_o = valid[idx] && tag[idx]==addr_tag && !flush_i && !rst_i`.
  - `fetch_data_o = data[{idx,off}]` whenever state is IDLE. Don't-care when not ready.
- Miss in IDLE (not ready, no flush):
  - Latch `line_base = {addr_tag, idx, OFF_W'0}`.
  - Word counter ← 0, go to REFILL.
- REFILL:
  - `mem_req_o = 1`, `mem_addr_o = line_base | counter`.
  - `fetch_ready_o = 0`.
  - On `mem_ack_i`: write `mem_data_i[31:2]` to `data[{idx, counter}]`, counter+1.
  - On the ack with counter == `LINE_WORDS-1`:
    - if no flush is pending: set `valid[idx]` and write `tag[idx]`;
    - return to IDLE.
- Line is always filled completely and in order from offset 0. No abort on fetch address change (branch). The next lookup after return uses the then-current `fetch_address_i`.
- Flush:
  - `flush_i` in IDLE: all `valid` cleared at the edge, state stays IDLE, no refill started that cycle.
  - `flush_i` during REFILL sets `flush_pending`. At refill completion the line is not validated and all `valid` are cleared. `flush_pending` clears on the IDLE transition.
- `mem_ack_i` while `mem_req_o = 0` is ignored.
- Refilling a line whose index already holds another tag: `valid[idx]` is cleared on entry to REFILL.

## Timing
- Hit: 0-cycle latency, combinational from `fetch_address_i`.
- Miss penalty with ack every cycle: `LINE_WORDS+1` cycles from miss cycle to hit.
  - Cycle 0: miss.
  - Cycles 1..LINE_WORDS: req/ack.
  - Cycle LINE_WORDS+1: hit.
- Wait states add one cycle each. `mem_req_o`/`mem_addr_o` are held stable until ack.
- Reset values:
  - state IDLE, all `valid` 0, counter 0, `flush_pending` 0;
  - `mem_req_o` 0, `fetch_ready_o` 0 during and after reset (all lines invalid);
  - `mem_addr_o` / `fetch_data_o` don't-care.
- Reset mid-refill: refill abandoned. `mem_req_o` low from the cycle after the reset edge. Late acks are ignored.
- Simultaneous `flush_i` and final ack: line not validated, all invalid.

## Structure
- Shared package `riskbes_pkg`:
  - state encoding (`ICACHE_IDLE`, `ICACHE_REFILL`);
  - instruction word width (30).
- Word counter uses the existing `increment` sub-module with `DATA_WIDTH=OFF_W`. Carry is unused; last-word detection is by compare.
- Single FSM always block; arrays in plain reg arrays; no further sub-modules.

## Test plan
- Reset, then addr 0x40 (word 0x10), ack every cycle, mem words 0x00000013+4k:
  - ready low for cycles 0..4; `mem_addr_o` = 0x10..0x13 on cycles 1..4;
  - cycle 5: ready=1, data=0x00000013>>2.
- After that fill, sweep addrs 0x10..0x13 → ready=1 each cycle, no `mem_req_o`.
- Conflict: addr word 0x10 then 0x10+LINES*LINE_WORDS → miss and refill. Returning to 0x10 → miss again.
- Ack with 2 wait states per word → `mem_addr_o` held stable while unacked; hit after 4*3+1 cycles.
- Flush in IDLE on a hit line → next cycle ready=0 and refill starts. Flush during 2nd refill word → after final ack ready=0 and a new refill begins.
- Reset asserted during 3rd refill word → `mem_req_o`=0 next cycle; a stray ack is ignored; the later lookup misses.

Source files
------------

// File: rtl/riskbes_pkg.sv
// Shared definitions for the riskbes core: cache FSM states and instruction width.
package riskbes_pkg;

    localparam int unsigned INSN_W = 30;

    typedef enum logic {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } icache_state_e;

endpackage

// File: rtl/increment.sv
// Generic +1 incrementer with carry out.
module increment #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] value_i,
    output logic [DATA_WIDTH-1:0] value_o,
    output logic                  carry_o
);

    assign {carry_o, value_o} = {1'b0, value_i} + (DATA_WIDTH+1)'(1);

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache: combinational lookup, in-order line refill
// over a single-word req/ack port, and full invalidate for fence.i.
module icache_controller
    import riskbes_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:2] fetch_address_i,
    output logic [31:2] fetch_data_o,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:2] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    icache_state_e state_q;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INSN_W-1:0] data_q [LINES*LINE_WORDS];

    logic [TAG_W+IDX_W-1:0] line_q;
    logic [OFF_W-1:0]       cnt_q;
    logic [OFF_W-1:0]       cnt_next;
    logic                   flush_pending_q;
    logic                   req_q;
    logic                   unused_carry;
    logic [1:0]             unused_mem_lsb;

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic [OFF_W-1:0] addr_off;
    logic [TAG_W-1:0] refill_tag;
    logic [IDX_W-1:0] refill_idx;
    logic             hit;

    assign addr_tag   = fetch_address_i[31 -: TAG_W];
    assign addr_idx   = fetch_address_i[2+OFF_W +: IDX_W];
    assign addr_off   = fetch_address_i[2 +: OFF_W];
    assign refill_tag = line_q[TAG_W+IDX_W-1:IDX_W];
    assign refill_idx = line_q[IDX_W-1:0];

    assign hit           = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign fetch_ready_o = (state_q == ICACHE_IDLE) && hit && !flush_i && !rst_i;
    assign fetch_data_o  = data_q[{addr_idx, addr_off}];

    assign mem_req_o      = req_q;
    assign mem_addr_o     = {line_q, cnt_q};
    assign unused_mem_lsb = mem_data_i[1:0];

    increment #(
        .DATA_WIDTH(OFF_W)
    ) u_word_cnt (
        .value_i (cnt_q),
        .value_o (cnt_next),
        .carry_o (unused_carry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ICACHE_IDLE;
            valid_q         <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            req_q           <= 1'b0;
        end else begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (flush_i) begin
                        valid_q <= '0;
                    end else if (!hit) begin
                        // Drop the old line up front so a conflicting tag can never hit mid-refill.
                        line_q            <= {addr_tag, addr_idx};
                        cnt_q             <= '0;
                        valid_q[addr_idx] <= 1'b0;
                        req_q             <= 1'b1;
                        state_q           <= ICACHE_REFILL;
                    end
                end
                ICACHE_REFILL: begin
                    if (flush_i) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        data_q[{refill_idx, cnt_q}] <= mem_data_i[31:2];
                        cnt_q <= cnt_next;
                        if (cnt_q == LAST_WORD) begin
                            // A flush seen at any point of the refill, including this cycle, wins.
                            if (flush_pending_q || flush_i) begin
                                valid_q <= '0;
                            end else begin
                                valid_q[refill_idx] <= 1'b1;
                                tag_q[refill_idx]   <= refill_tag;
                            end
                            flush_pending_q <= 1'b0;
                            req_q           <= 1'b0;
                            state_q         <= ICACHE_IDLE;
                        end
                    end
                end
                default: state_q <= ICACHE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: directed sequences, a vector table
// and a randomized run against a line-level cache/memory model.
module tb_icache_controller;

    localparam int unsigned LW    = 4;
    localparam int unsigned NL    = 64;
    localparam int unsigned OFF_W = $clog2(LW);
    localparam int unsigned IDX_W = $clog2(NL);

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [29:0] fetch_data;
    logic        ready;
    logic        flush;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    icache_controller #(
        .LINE_WORDS(LW),
        .LINES     (NL)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .fetch_address_i (addr),
        .fetch_data_o    (fetch_data),
        .fetch_ready_o   (ready),
        .flush_i         (flush),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_ack_i       (mem_ack),
        .mem_data_i      (mem_data)
    );

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return 32'h13 + (({2'b00, a} - 32'h10) << 2);
    endfunction

    function automatic logic [29:0] exp_data(input logic [29:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return w[31:2];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Memory responder: acks after `waits` idle cycles, tracks address stability.
    int          waits     = 0;
    bit          force_ack = 0;
    int          wait_cnt  = 0;
    int          unstable  = 0;
    bit          prev_pending = 0;
    logic [29:0] prev_addr;

    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (force_ack) begin
                mem_ack = 1'b1;
                mem_data = 32'hDEAD_BEEF;
                wait_cnt = 0;
                prev_pending = 0;
            end else if (mem_req === 1'b1) begin
                if (prev_pending && mem_addr !== prev_addr) unstable++;
                if (wait_cnt >= waits) begin
                    mem_ack = 1'b1;
                    mem_data = mem_word(mem_addr);
                    wait_cnt = 0;
                    prev_pending = 0;
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                    prev_pending = 1;
                    prev_addr = mem_addr;
                end
            end else begin
                mem_ack = 1'b0;
                wait_cnt = 0;
                prev_pending = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [29:0] a, input logic fl);
        tick();
        addr  = a;
        flush = fl;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        tick();
        flush = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for the hit that ends a refill; n counts cycles since the miss cycle.
    task automatic wait_fill(input string name, input logic [29:0] a, input int exp_n, input int start);
        int n;
        bit got;
        n   = start;
        got = 0;
        while (!got && n < start + 300) begin
            next_cycle();
            n++;
            got = ready;
        end
        check({name, " latency"}, n, exp_n);
        check({name, " data"}, fetch_data, exp_data(a));
    endtask

    typedef struct {
        logic [29:0] addr;
        logic        exp_ready;
        logic [29:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [29:0] a, input logic r);
        vec_t v;
        v.addr      = a;
        v.exp_ready = r;
        v.exp_data  = exp_data(a);
        return v;
    endfunction

    logic [1:0]       m_valid_dummy;
    bit               m_valid [NL];
    int unsigned      m_tag   [NL];

    initial begin
        vecs[0]  = mk(30'h010, 1'b1);
        vecs[1]  = mk(30'h011, 1'b1);
        vecs[2]  = mk(30'h012, 1'b1);
        vecs[3]  = mk(30'h013, 1'b1);
        vecs[4]  = mk(30'h014, 1'b0);
        vecs[5]  = mk(30'h017, 1'b1);
        vecs[6]  = mk(30'h010, 1'b1);
        vecs[7]  = mk(30'h110, 1'b0);
        vecs[8]  = mk(30'h112, 1'b1);
        vecs[9]  = mk(30'h010, 1'b0);
        vecs[10] = mk(30'h013, 1'b1);
        vecs[11] = mk(30'h015, 1'b1);

        rst   = 1'b1;
        addr  = 30'h10;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset ready", ready, 0);
            check("reset req", mem_req, 0);
        end

        // First fill of word 0x10 with ack every cycle.
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("fill0 miss ready", ready, 0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            check("fill0 ready", ready, 0);
            check("fill0 req", mem_req, 1);
            check("fill0 addr", mem_addr, 30'h10 + 30'(k - 1));
        end
        next_cycle();
        check("fill0 hit", ready, 1);
        check("fill0 data", fetch_data, 30'h4);

        foreach (vecs[i]) begin
            lookup(vecs[i].addr, 1'b0);
            check($sformatf("vec%0d ready", i), ready, vecs[i].exp_ready);
            if (vecs[i].exp_ready) begin
                check($sformatf("vec%0d data", i), fetch_data, vecs[i].exp_data);
                check($sformatf("vec%0d req", i), mem_req, 0);
            end else begin
                wait_fill($sformatf("vec%0d fill", i), vecs[i].addr, LW + 1, 0);
            end
        end

        // Two wait states per word.
        waits = 2;
        lookup(30'h20, 1'b0);
        check("wait miss", ready, 0);
        wait_fill("wait", 30'h20, 4 * 3 + 1, 0);
        check("wait addr stable", unstable, 0);
        waits = 0;

        // Flush in IDLE on a hit line.
        lookup(30'h20, 1'b0);
        check("pre-flush hit", ready, 1);
        lookup(30'h20, 1'b1);
        check("flush cycle ready", ready, 0);
        check("flush cycle req", mem_req, 0);
        next_cycle();
        check("post-flush miss", ready, 0);
        check("post-flush no req yet", mem_req, 0);
        next_cycle();
        check("post-flush req", mem_req, 1);
        check("post-flush addr", mem_addr, 30'h20);
        wait_fill("post-flush", 30'h20, LW + 1, 1);

        // Flush during the 2nd refill word.
        lookup(30'h30, 1'b0);
        check("fr2 miss", ready, 0);
        next_cycle();
        tick();
        flush = 1'b1;
        @(negedge clk);
        next_cycle();
        next_cycle();
        next_cycle();
        check("fr2 not validated", ready, 0);
        check("fr2 idle req", mem_req, 0);
        next_cycle();
        check("fr2 re-req", mem_req, 1);
        check("fr2 re-addr", mem_addr, 30'h30);
        wait_fill("fr2 refill", 30'h30, LW + 1, 1);
        lookup(30'h20, 1'b0);
        check("fr2 others invalid", ready, 0);
        wait_fill("fr2 other refill", 30'h20, LW + 1, 0);

        // Flush coinciding with the final ack.
        lookup(30'h40, 1'b0);
        check("frl miss", ready, 0);
        next_cycle();
        next_cycle();
        next_cycle();
        tick();
        flush = 1'b1;
        @(negedge clk);
        next_cycle();
        check("frl not validated", ready, 0);
        next_cycle();
        check("frl re-req", mem_req, 1);
        wait_fill("frl refill", 30'h40, LW + 1, 1);
        lookup(30'h30, 1'b0);
        check("frl others invalid", ready, 0);
        wait_fill("frl other refill", 30'h30, LW + 1, 0);

        // Reset during the 3rd refill word, followed by a stray ack.
        lookup(30'h50, 1'b0);
        check("rst miss", ready, 0);
        next_cycle();
        next_cycle();
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        force_ack = 1;
        @(negedge clk);
        check("rst req dropped", mem_req, 0);
        check("rst lookup misses", ready, 0);
        tick();
        force_ack = 0;
        @(negedge clk);
        check("rst re-req", mem_req, 1);
        check("rst re-addr", mem_addr, 30'h50);
        wait_fill("rst refill", 30'h50, LW + 1, 1);
        lookup(30'h10, 1'b0);
        check("rst old line gone", ready, 0);
        wait_fill("rst old refill", 30'h10, LW + 1, 0);

        // Randomized run against a line-level model, starting from a clean cache.
        lookup(30'h0, 1'b1);
        foreach (m_valid[i]) m_valid[i] = 0;
        for (int i = 0; i < 150; i++) begin
            int unsigned t, ix, o;
            logic [29:0] a;
            bit exp_hit;
            t  = $urandom_range(0, 3);
            ix = $urandom_range(0, 7);
            o  = $urandom_range(0, LW - 1);
            a  = 30'((t << (IDX_W + OFF_W)) + (ix << OFF_W) + o);
            waits = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) begin
                lookup(a, 1'b1);
                check("rand flush ready", ready, 0);
                foreach (m_valid[j]) m_valid[j] = 0;
            end else begin
                lookup(a, 1'b0);
                exp_hit = m_valid[ix] && (m_tag[ix] == t);
                check($sformatf("rand%0d ready", i), ready, exp_hit);
                if (exp_hit) begin
                    check($sformatf("rand%0d data", i), fetch_data, exp_data(a));
                end else begin
                    wait_fill($sformatf("rand%0d fill", i), a, LW * (waits + 1) + 1, 0);
                    m_valid[ix] = 1;
                    m_tag[ix]   = t;
                end
            end
        end
        waits = 0;
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
